// File: rtl/fibonacci_pkg.sv
// Shared types and width helpers for the Fibonacci stream blocks.
package fibonacci_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, PASS, FAIL} fib_chk_state_t;

  function automatic int count_width(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

  // A disabled timeout still needs a 1-bit counter so the port-free logic stays legal.
  function automatic int timer_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/fib_ref_seq.sv
// Modulo-2^N Fibonacci reference: expected walks 0,1,1,2,3,... one term per advance.
module fib_ref_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         advance,
  output logic [N-1:0] expected
);

  logic [N-1:0] a;
  logic [N-1:0] b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= N'(1);
    end else if (clear) begin
      a <= '0;
      b <= N'(1);
    end else if (advance) begin
      a <= b;
      b <= a + b;
    end
  end

  assign expected = a;

endmodule

// File: rtl/fibonacci_checker.sv
// Checks a Fibonacci sample stream against an internal reference, with timeout and error capture.
//   state | meaning
//   IDLE  | not armed, outputs hold
//   CHECK | comparing samples, timeout running
//   PASS  | MAX_TERMS matches seen, verdict held
//   FAIL  | mismatch or timeout, verdict and error details held
module fibonacci_checker
  import fibonacci_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int MAX_TERMS = 16,
  parameter  int TIMEOUT   = 32,
  localparam int CW        = count_width(MAX_TERMS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          err_timeout,
  output logic [CW-1:0] match_count,
  output logic [CW-1:0] err_index,
  output logic [N-1:0]  err_expected,
  output logic [N-1:0]  err_actual
);

  localparam int            TW        = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] LAST_TERM = CW'(MAX_TERMS - 1);

  fib_chk_state_t state, state_nxt;
  logic [TW-1:0]  tmo_cnt;
  logic [N-1:0]   expected;
  logic           checking;
  logic           hit;
  logic           miss;
  logic           tmo;
  logic           last;

  fib_ref_seq #(.N(N)) u_ref (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start),
    .advance  (hit),
    .expected (expected)
  );

  // start always wins over a coincident sample or timeout
  assign checking = (state == CHECK) && !start;
  assign hit      = checking && in_valid && (in_data == expected);
  assign miss     = checking && in_valid && (in_data != expected);
  assign tmo      = (TIMEOUT > 0) && checking && !in_valid && (tmo_cnt == TMO_LAST);
  assign last     = hit && (match_count == LAST_TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)            state_nxt = CHECK;
    else if (last)        state_nxt = PASS;
    else if (miss || tmo) state_nxt = FAIL;
  end

  always_comb begin
    busy = (state == CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      err_timeout  <= 1'b0;
      match_count  <= '0;
      err_index    <= '0;
      err_expected <= '0;
      err_actual   <= '0;
      tmo_cnt      <= '0;
    end else if (start) begin
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      err_timeout  <= 1'b0;
      match_count  <= '0;
      err_index    <= '0;
      err_expected <= '0;
      err_actual   <= '0;
      tmo_cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (hit) begin
        match_count <= match_count + 1'b1;
        tmo_cnt     <= '0;
        if (last) begin
          pass <= 1'b1;
          done <= 1'b1;
        end
      end else if (miss) begin
        fail         <= 1'b1;
        done         <= 1'b1;
        err_index    <= match_count;
        err_expected <= expected;
        err_actual   <= in_data;
      end else if (tmo) begin
        fail         <= 1'b1;
        err_timeout  <= 1'b1;
        done         <= 1'b1;
        err_index    <= match_count;
        err_expected <= expected;
        err_actual   <= '0;
      end else if ((TIMEOUT > 0) && checking && !in_valid) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker (N=8, MAX_TERMS=16, TIMEOUT=32).
module tb_fibonacci_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       busy, done, pass, fail, err_timeout;
  logic [4:0] match_count, err_index;
  logic [7:0] err_expected, err_actual;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic       ps;
    logic       fl;
    logic       to;
    logic [4:0] mc;
    logic [4:0] idx;
    logic [7:0] ex;
    logic [7:0] ac;
    int         at;
  } verdict_t;

  verdict_t sb[$];
  verdict_t v;
  logic [7:0] fib_tab [16];

  fibonacci_checker #(.N(8), .MAX_TERMS(16), .TIMEOUT(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .err_timeout  (err_timeout),
    .match_count  (match_count),
    .err_index    (err_index),
    .err_expected (err_expected),
    .err_actual   (err_actual)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no verdict", cyc);
      end else begin
        v = sb.pop_front();
        chk("verdict_cycle", cyc, v.at);
        chk("pass", {31'd0, pass}, {31'd0, v.ps});
        chk("fail", {31'd0, fail}, {31'd0, v.fl});
        chk("err_timeout", {31'd0, err_timeout}, {31'd0, v.to});
        chk("match_count", {27'd0, match_count}, {27'd0, v.mc});
        chk("err_index", {27'd0, err_index}, {27'd0, v.idx});
        chk("err_expected", {24'd0, err_expected}, {24'd0, v.ex});
        chk("err_actual", {24'd0, err_actual}, {24'd0, v.ac});
      end
    end
  end

  task automatic push_v(input logic ps, input logic fl, input logic to, input int mc,
                        input int idx, input int ex, input int ac, input int at);
    verdict_t e;
    e.ps = ps; e.fl = fl; e.to = to;
    e.mc = 5'(mc); e.idx = 5'(idx); e.ex = 8'(ex); e.ac = 8'(ac); e.at = at;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic with_valid, input logic [7:0] d);
    start = 1'b1; in_valid = with_valid; in_data = d;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
    chk({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
    chk({tag, "_match_count"}, {27'd0, match_count}, 32'd0);
    chk({tag, "_err_index"}, {27'd0, err_index}, 32'd0);
    chk({tag, "_err_expected"}, {24'd0, err_expected}, 32'd0);
    chk({tag, "_err_actual"}, {24'd0, err_actual}, 32'd0);
  endtask

  initial begin
    fib_tab = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};

    // reset values
    #3;
    chk_cleared("reset");
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    #20 rst_n = 1'b1;
    idle(2);
    beat(8'd0);
    chk("idle_ignores_valid", {27'd0, match_count}, 32'd0);

    // full back-to-back pass, including the wrapped terms 121 and 98
    do_start(1'b0, 8'd0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) beat(fib_tab[i]);
    push_v(1'b1, 1'b0, 1'b0, 16, 0, 0, 0, cyc);
    idle(3);
    chk("busy_after_pass", {31'd0, busy}, 32'd0);

    // mismatch on the fifth term; restart from PASS clears the verdict
    do_start(1'b0, 8'd0);
    chk_cleared("restart_from_pass");
    beat(8'd0); beat(8'd1); beat(8'd1); beat(8'd2); beat(8'd4);
    push_v(1'b0, 1'b1, 1'b0, 4, 4, 3, 4, cyc);
    beat(8'd5); beat(8'd8);
    idle(1);
    chk("fail_hold_fail", {31'd0, fail}, 32'd1);
    chk("fail_hold_count", {27'd0, match_count}, 32'd4);
    chk("fail_hold_actual", {24'd0, err_actual}, 32'd4);

    // timeout exactly 32 cycles after the last beat; restart from FAIL clears
    do_start(1'b0, 8'd0);
    chk_cleared("restart_from_fail");
    beat(8'd0); beat(8'd1);
    push_v(1'b0, 1'b1, 1'b1, 2, 2, 1, 0, cyc + 32);
    idle(40);

    // a 31-cycle gap is tolerated
    do_start(1'b0, 8'd0);
    beat(8'd0);
    idle(31);
    beat(8'd1);
    chk("gap31_fail", {31'd0, fail}, 32'd0);
    chk("gap31_busy", {31'd0, busy}, 32'd1);
    chk("gap31_count", {27'd0, match_count}, 32'd2);

    // sample coincident with start is dropped
    do_start(1'b1, 8'd7);
    beat(8'd0); beat(8'd1); beat(8'd1);
    chk("start_drop_count", {27'd0, match_count}, 32'd3);
    chk("start_drop_fail", {31'd0, fail}, 32'd0);

    // async reset mid-check after 5 matches: no verdict, inputs ignored afterwards
    do_start(1'b0, 8'd0);
    for (int i = 0; i < 5; i++) beat(fib_tab[i]);
    #2 rst_n = 1'b0;
    #1;
    chk_cleared("midreset");
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    beat(8'd0); beat(8'd1);
    chk("post_reset_count", {27'd0, match_count}, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    // gapped stream, one beat every third cycle
    do_start(1'b0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      beat(fib_tab[i]);
      if (i == 15) push_v(1'b1, 1'b0, 1'b0, 16, 0, 0, 0, cyc);
      idle(2);
    end
    idle(5);

    chk("pending_verdicts", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
Stream checker for Fibonacci sources. It consumes one N-bit sample per in_valid beat and compares it against an internal modulo-2^N reference sequence 0,1,1,2,3,5,... It reports pass after MAX_TERMS consecutive matches. It reports fail on the first mismatch or on an inter-sample timeout, and captures error details. It sits downstream of a Fibonacci generator, as a self-check and BIST monitor on its fib_out/done stream.

Parameters:
N, 8, sample width; the reference sequence wraps modulo 2^N.
MAX_TERMS, 16, matches required for pass (>=1).
TIMEOUT, 32, max cycles without in_valid while checking before fail; 0 disables the timeout.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  pulse: (re)arm checker, clear status and the reference sequence
in_valid  input  1  sample strobe (driven from the generator's done)
in_data  input  N  sample value
busy  output  1  high while checking
done  output  1  one-cycle pulse when a verdict (pass or fail) is reached
pass  output  1  sticky: MAX_TERMS matches seen
fail  output  1  sticky: mismatch or timeout
err_timeout  output  1  sticky: the fail cause was a timeout
match_count  output  CW  matches so far; CW = $clog2(MAX_TERMS+1)
err_index  output  CW  term index of the failing sample (or of the expected sample on timeout)
err_expected  output  N  expected value at failure
err_actual  output  N  received value at failure (0 on timeout)

Behaviour:
- Reset: all outputs 0; state IDLE; ref a=0, b=1; timeout counter 0.
- States: IDLE, CHECK, PASS, FAIL.
- start in any state: next cycle is CHECK; a=0, b=1; match_count=0; pass/fail/err_* cleared; timeout counter cleared.
- start and in_valid in the same cycle: start wins and the sample is discarded.
- IDLE, PASS, FAIL: in_valid is ignored, all outputs hold, busy=0.
- CHECK: busy=1. On in_valid, compare in_data with a; the result is registered with 1-cycle latency.
- Match in CHECK: a<=b, b<=(a+b) mod 2^N, match_count+1, timeout counter cleared.
  - If the new match_count equals MAX_TERMS: go to PASS, pass=1, done pulse.
- Mismatch in CHECK: go to FAIL, fail=1, done pulse.
  - Capture err_index=match_count, err_expected=a, err_actual=in_data.
  - The reference sequence does not advance.
- Timeout (TIMEOUT>0): the counter increments each CHECK cycle without in_valid.
  - On reaching TIMEOUT: go to FAIL, fail=1, err_timeout=1, done pulse.
  - Capture err_index=match_count, err_expected=a, err_actual=0.
- in_valid in the cycle the counter would reach TIMEOUT: the sample is checked and no timeout occurs.
- done is high for exactly one cycle per verdict, and is never asserted together with start's effect.
- pass and fail are mutually exclusive and hold until the next start or reset.
- Reset mid-CHECK: immediate return to reset values; no done pulse.
- Arithmetic: the a+b adder is N bits, carry dropped. This matches generator wrap, so a wrapping stream still passes.

Decomposition:
- fibonacci_pkg holds:
  - typedef enum logic [1:0] {IDLE, CHECK, PASS, FAIL} fib_chk_state_t;
  - localparam helpers for CW and the timeout counter width ($clog2(TIMEOUT+1)).
- Sub-module fib_ref_seq (N): holds a/b, with inputs clear and advance and output expected = a. Reusable by other Fibonacci blocks.
- FSM, counters and error capture stay in fibonacci_checker.

Test Plan:
- N=8, MAX_TERMS=16: start, then 16 in_valid beats 0,1,1,2,3,5,8,13,21,34,55,89,144,233,121,98 -> pass=1, done pulse 1 cycle after the last beat, match_count=16, fail=0.
- Mismatch: start, then send 0,1,1,2,4 -> fail=1, err_index=4, err_expected=3, err_actual=4, err_timeout=0, match_count=4; further beats do not change the outputs.
- Timeout, TIMEOUT=32: start, send 0,1, then idle -> fail=1, err_timeout=1, err_index=2, err_expected=1 exactly 32 cycles after the last beat. Separately, a gap of 31 idle cycles then a valid sample -> no fail.
- start coincident with in_valid carrying 7: that sample is dropped; the following 0,1,1 then matches (match_count=3). start in PASS or FAIL clears pass/fail/err_* and re-arms.
- Reset mid-CHECK after 5 matches: all outputs 0, state IDLE, no done pulse; in_valid then ignored until start.
- Gapped stream: in_valid every 3rd cycle with the correct values -> identical verdict and match_count to the back-to-back case.
